sb_param_cfgchain: RTL

- Parametrised successor of the fixed-width routing switch block: generic output tracks, each driven by a MUX_SIZE:1 track mux over a flat input bus, using a fixed strided connectivity pattern.
- Configuration arrives on a serial ccff chain clocked by prog_clk.
- New over prior generation: shadow/active double-buffering with explicit commit, bit counter with done flag, error reporting.
- Sits in the FPGA routing fabric; chains head-to-tail with neighbouring switch/connection blocks.

---
 rtl/sb_cfg_pkg.sv | 18 +
 rtl/sb_track_mux.sv | 27 ++
 rtl/sb_param_cfgchain.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the parametrised switch block configuration chain.
// Consumers honour the SB_CFG_PARITY_EN build macro, which appends an even-parity bit to the chain.
package sb_cfg_pkg;

  // Distance of the parity bit from the chain length: it occupies chain[CFG_LEN-1]
  localparam int SB_PARITY_TAIL_OFS = 1;

  // Input index feeding tap k of track mux o under the strided connectivity pattern
  function automatic int sb_mux_src(input int o, input int k, input int stride, input int in_w);
    return (o + k * stride) % in_w;
  endfunction

  // Select width for a mux with mux_size inputs, never narrower than one bit
  function automatic int sb_sel_w(input int mux_size);
    return (mux_size < 2) ? 1 : $clog2(mux_size);
  endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One MUX_SIZE:1 routing track mux.
// A select code with no matching tap drives 0 and raises sel_err.
module sb_track_mux
  import sb_cfg_pkg::*;
#(
  parameter int MUX_SIZE = 6,
  parameter int SEL_W    = sb_sel_w(MUX_SIZE)
) (
  input  logic [MUX_SIZE-1:0] mux_in,
  input  logic [SEL_W-1:0]    sel,
  output logic                mux_out,
  output logic                sel_err
);

  // Decode the select against each legal tap; unmatched codes fall through as an error
  always_comb begin
    mux_out = 1'b0;
    sel_err = 1'b1;
    for (int k = 0; k < MUX_SIZE; k++) begin
      if (sel == SEL_W'(k)) begin
        mux_out = mux_in[k];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sb_param_cfgchain.sv
// Parametrised routing switch block with a double-buffered serial ccff configuration chain.
// The shadow chain shifts on prog_clk and is copied to the active selects only on a legal commit.
// Build macro SB_CFG_PARITY_EN adds an even-parity bit at the tail of the chain.
module sb_param_cfgchain
  import sb_cfg_pkg::*;
#(
  parameter int IN_W     = 27,
  parameter int OUT_W    = 27,
  parameter int MUX_SIZE = 6,
  parameter int STRIDE   = 4
) (
  input  logic            prog_clk,
  input  logic            prog_reset,
  input  logic            ccff_head,
  input  logic            ccff_en,
  input  logic            cfg_commit,
  input  logic [IN_W-1:0] in_bus,
  output logic [OUT_W-1:0] route_out,
  output logic            ccff_tail,
  output logic            cfg_done,
  output logic            cfg_err,
  output logic            sel_err
);

  localparam int SEL_W = sb_sel_w(MUX_SIZE);
  localparam int ACT_W = OUT_W * SEL_W;
`ifdef SB_CFG_PARITY_EN
  localparam int CFG_LEN = ACT_W + SB_PARITY_TAIL_OFS;
`else
  localparam int CFG_LEN = ACT_W;
`endif
  localparam int CNT_W = $clog2(CFG_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_LEN);

  logic [CFG_LEN-1:0] chain;
  logic [ACT_W-1:0]   active;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_next;
  logic               done_q;
  logic               err_q;
  logic               do_shift;
  logic               parity_ok;
  logic               commit_ok;
  logic               commit_reject;
  logic [OUT_W-1:0]   mux_err;

`ifdef SB_CFG_PARITY_EN
  assign parity_ok = ~(^chain);
`else
  assign parity_ok = 1'b1;
`endif

  // A commit request always wins over shifting on the same edge
  assign do_shift      = ccff_en & ~cfg_commit;
  assign commit_ok     = cfg_commit & done_q & parity_ok;
  assign commit_reject = cfg_commit & ~commit_ok;

  // Next bit count: cleared by any commit attempt on a full chain, otherwise saturating increment
  always_comb begin
    bit_cnt_next = bit_cnt;
    if (cfg_commit && done_q) begin
      bit_cnt_next = '0;
    end else if (do_shift && (bit_cnt != CNT_FULL)) begin
      bit_cnt_next = bit_cnt + 1'b1;
    end
  end

  // Shadow chain: serial shift from ccff_head toward ccff_tail
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      chain <= '0;
    end else if (do_shift) begin
      chain <= CFG_LEN'({chain, ccff_head});
    end
  end

  // Bit counter and registered done flag tracking a full chain
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      bit_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt_next;
      done_q  <= (bit_cnt_next == CNT_FULL);
    end
  end

  // Active selects load from the shadow chain only on an accepted commit
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      active <= '0;
    end else if (commit_ok) begin
      active <= chain[ACT_W-1:0];
    end
  end

  // Sticky error for early or parity-failing commits
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      err_q <= 1'b0;
    end else if (commit_reject) begin
      err_q <= 1'b1;
    end
  end

  for (genvar o = 0; o < OUT_W; o++) begin : g_track
    logic [MUX_SIZE-1:0] taps;
    for (genvar k = 0; k < MUX_SIZE; k++) begin : g_tap
      assign taps[k] = in_bus[sb_mux_src(o, k, STRIDE, IN_W)];
    end
    sb_track_mux #(
      .MUX_SIZE(MUX_SIZE),
      .SEL_W   (SEL_W)
    ) u_mux (
      .mux_in (taps),
      .sel    (active[o*SEL_W +: SEL_W]),
      .mux_out(route_out[o]),
      .sel_err(mux_err[o])
    );
  end

  assign sel_err   = |mux_err;
  assign ccff_tail = chain[CFG_LEN-1];
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule
